// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall bus type,
// per-stage Stop/NoStop values, named stall codes and FSM state encodings.
package pipe_stall_ctrl_pkg;

  // Stall bus layout: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
  localparam int STALL_BUS_W = 6;
  typedef logic [STALL_BUS_W-1:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Every code stops a contiguous run of low stages, so the first
  // NoStop stage above the run receives a bubble.
  localparam stall_bus_t STALL_NONE    = {STALL_BUS_W{NO_STOP}};
  localparam stall_bus_t STALL_LOADUSE = 6'b000111;  // EX gets a bubble
  localparam stall_bus_t STALL_DIV     = 6'b001111;  // MEM gets a bubble
  localparam stall_bus_t STALL_MEM     = 6'b011111;  // WB gets a bubble

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// Saturating event counter with enable; generic enough for any
// performance counter in the core.
module stall_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, holding at all-ones once reached.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline controller: arbitrates load-use, divider and data-SRAM
// stalls into the stage stall bus, sequences divider occupancy with a
// watchdog, registers the exception flush/redirect and counts stall cycles.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int STALL_W     = STALL_BUS_W,
  parameter int DIV_MAX_CYC = 40,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               div_start,
  input  logic               div_ready,
  input  logic               mem_wait,
  input  logic               except_valid,
  input  logic [31:0]        except_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               div_busy,
  output logic               div_timeout,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int DIV_CNT_W = $clog2(DIV_MAX_CYC + 1);

  ctrl_state_t          state;
  ctrl_state_t          state_next;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic [DIV_CNT_W-1:0] div_cnt_inc;
  logic                 ready_seen;
  logic                 ready_eff;
  logic                 div_done;
  logic                 wd_hit;
  logic                 take_except;
  stall_bus_t           stall_code;

  // A ready pulse that arrived under a MEM wait still counts once MEM frees.
  assign ready_eff   = div_ready | ready_seen;
  assign div_cnt_inc = div_cnt + DIV_CNT_W'(1);

  // The divide completes only when its result can move on (MEM not waiting).
  assign div_done    = (state == DIV_WAIT) && !except_valid && ready_eff && !mem_wait;
  assign wd_hit      = (state == DIV_WAIT) && !except_valid && !ready_eff &&
                       (div_cnt_inc == DIV_CNT_W'(DIV_MAX_CYC));

  // An exception arriving while already flushing is dropped.
  assign take_except = except_valid && (state != FLUSH);

  assign div_busy    = (state == DIV_WAIT);

  // Next-state selection for the divide/flush sequencer.
  always_comb begin
    // NOTE: assigning a default before any branch keeps every path driven,
    // so no latch is inferred for combinational outputs.
    state_next = state;
    case (state)
      IDLE: begin
        if (except_valid)   state_next = FLUSH;
        else if (div_start) state_next = DIV_WAIT;
      end
      DIV_WAIT: begin
        if (except_valid)           state_next = FLUSH;
        else if (div_done || wd_hit) state_next = IDLE;
      end
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stall arbitration, highest priority first; forced idle during reset.
  always_comb begin
    stall_code = STALL_NONE;
    if (rst || except_valid || (state == FLUSH)) begin
      stall_code = STALL_NONE;
    end else if (mem_wait) begin
      stall_code = STALL_MEM;
    end else if ((state == DIV_WAIT) && !ready_eff) begin
      stall_code = STALL_DIV;
    end else if (stallreq_id) begin
      stall_code = STALL_LOADUSE;
    end
  end

  assign stall = stall_code;

  // State register, divide counter, ready latch, redirect and watchdog flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      ready_seen  <= 1'b0;
      flush       <= 1'b0;
      new_pc      <= '0;
      div_timeout <= 1'b0;
    end else begin
      state <= state_next;
      flush <= take_except;
      if (take_except) new_pc <= except_pc;
      if (wd_hit) div_timeout <= 1'b1;

      // Counter and ready latch live only inside DIV_WAIT; outside they
      // rest at zero so each divide starts from a clean count.
      if (state != DIV_WAIT) begin
        div_cnt    <= '0;
        ready_seen <= 1'b0;
      end else begin
        div_cnt <= div_cnt_inc;
        if (div_ready && mem_wait) ready_seen <= 1'b1;
      end
    end
  end

  stall_perf_cnt #(
    .W (CNT_W)
  ) u_stall_perf_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (|stall_code),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios for the key
// sequences plus a randomized run against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  localparam int DIV_MAX = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, div_start, div_ready, mem_wait, except_valid;
  logic [31:0] except_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        div_busy, div_timeout;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a divide "in flight" with elapsed cycles, a latched
  // ready, a pending flush, redirect PC, sticky timeout and stall count.
  bit          m_busy, m_ready_latched, m_flushing, m_timeout;
  int          m_elapsed;
  logic [31:0] m_pc, m_cnt;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .STALL_W     (6),
    .DIV_MAX_CYC (DIV_MAX),
    .CNT_W       (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .div_start    (div_start),
    .div_ready    (div_ready),
    .mem_wait     (mem_wait),
    .except_valid (except_valid),
    .except_pc    (except_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .div_busy     (div_busy),
    .div_timeout  (div_timeout),
    .stall_cnt    (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit id, input bit st, input bit rdy, input bit mw,
                       input bit ex, input logic [31:0] pc);
    stallreq_id  = id;
    div_start    = st;
    div_ready    = rdy;
    mem_wait     = mw;
    except_valid = ex;
    except_pc    = pc;
  endtask

  task automatic model_reset();
    m_busy = 0; m_ready_latched = 0; m_flushing = 0; m_timeout = 0;
    m_elapsed = 0; m_pc = '0; m_cnt = '0;
  endtask

  // Number of stopped low stages, turned into a contiguous mask.
  function automatic logic [5:0] model_stall();
    int depth;
    if (rst || except_valid || m_flushing)             depth = 0;
    else if (mem_wait)                                 depth = 5;
    else if (m_busy && !(div_ready || m_ready_latched)) depth = 4;
    else if (stallreq_id)                              depth = 3;
    else                                               depth = 0;
    return 6'((1 << depth) - 1);
  endfunction

  task automatic model_update();
    bit ready_now;
    if (model_stall() != 6'd0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    ready_now = div_ready || m_ready_latched;
    if (m_flushing) begin
      m_flushing = 0;
    end else if (except_valid) begin
      m_flushing = 1;
      m_pc       = except_pc;
      m_busy     = 0;
    end else if (m_busy) begin
      m_elapsed++;
      if (ready_now && !mem_wait)                      m_busy = 0;
      else if (!ready_now && m_elapsed == DIV_MAX) begin m_timeout = 1; m_busy = 0; end
      else if (div_ready)                              m_ready_latched = 1;
    end else if (div_start) begin
      m_busy = 1; m_elapsed = 0; m_ready_latched = 0;
    end
  endtask

  task automatic check_outputs();
    check("stall",       32'(stall),       32'(model_stall()));
    check("flush",       32'(flush),       32'(m_flushing));
    check("new_pc",      new_pc,           m_pc);
    check("div_busy",    32'(div_busy),    32'(m_busy));
    check("div_timeout", 32'(div_timeout), 32'(m_timeout));
    check("stall_cnt",   stall_cnt,        m_cnt);
  endtask

  // Entered at a negedge with inputs already driven; leaves at the next one.
  task automatic run_cycle();
    #2;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 32'h0);
    run_cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 32'h0);
    model_reset();
    #1;
    check("rst_stall_memwait", 32'(stall), 32'(STALL_NONE));
    @(negedge clk);
    check("rst_flush",       32'(flush),       32'd0);
    check("rst_new_pc",      new_pc,           32'd0);
    check("rst_div_busy",    32'(div_busy),    32'd0);
    check("rst_div_timeout", 32'(div_timeout), 32'd0);
    check("rst_stall_cnt",   stall_cnt,        32'd0);
    apply_reset();

    // Load-use: one cycle of 000111, then the counter shows one.
    drive(1, 0, 0, 0, 0, 32'h0);
    #1 check("lu_stall", 32'(stall), 32'(STALL_LOADUSE));
    run_cycle();
    drive(0, 0, 0, 0, 0, 32'h0);
    #1 check("lu_after_stall", 32'(stall), 32'd0);
    check("lu_cnt", stall_cnt, 32'd1);
    run_cycle();

    // Divide: start at 0, ready at 33.
    apply_reset();
    drive(0, 1, 0, 0, 0, 32'h0);
    run_cycle();
    for (int c = 1; c <= 32; c++) begin
      drive(0, 0, 0, 0, 0, 32'h0);
      if (c == 1 || c == 32) begin
        #1 check("div_stall", 32'(stall), 32'(STALL_DIV));
      end
      run_cycle();
    end
    drive(0, 0, 1, 0, 0, 32'h0);
    #1 check("div_ready_stall", 32'(stall), 32'd0);
    check("div_busy_33", 32'(div_busy), 32'd1);
    run_cycle();
    drive(0, 0, 0, 0, 0, 32'h0);
    #1 check("div_busy_34", 32'(div_busy), 32'd0);
    check("div_cnt_32", stall_cnt, 32'd32);
    run_cycle();

    // Divide overlapped with MEM wait 5..10, ready at 7.
    apply_reset();
    drive(0, 1, 0, 0, 0, 32'h0);
    run_cycle();
    for (int c = 1; c <= 10; c++) begin
      drive(0, 0, (c == 7), (c >= 5), 0, 32'h0);
      if (c == 10) begin
        #1 check("ovl_stall_10", 32'(stall), 32'(STALL_MEM));
      end
      run_cycle();
    end
    drive(0, 0, 0, 0, 0, 32'h0);
    #1 check("ovl_stall_11", 32'(stall), 32'd0);
    run_cycle();
    drive(0, 0, 0, 0, 0, 32'h0);
    #1 check("ovl_busy_12", 32'(div_busy), 32'd0);
    check("ovl_timeout", 32'(div_timeout), 32'd0);
    run_cycle();

    // Exception at cycle 4 of DIV_WAIT; a second one during FLUSH is dropped.
    apply_reset();
    drive(0, 1, 0, 0, 0, 32'h0);
    run_cycle();
    for (int c = 1; c <= 3; c++) idle_cycle();
    drive(0, 0, 0, 0, 1, 32'hBFC0_0380);
    #1 check("exc_stall", 32'(stall), 32'd0);
    run_cycle();
    drive(0, 0, 0, 0, 1, 32'h1234_5678);
    #1 check("exc_flush", 32'(flush), 32'd1);
    check("exc_new_pc", new_pc, 32'hBFC0_0380);
    check("exc_busy", 32'(div_busy), 32'd0);
    run_cycle();
    drive(0, 0, 0, 0, 0, 32'h0);
    #1 check("exc_flush_end", 32'(flush), 32'd0);
    check("exc_pc_hold", new_pc, 32'hBFC0_0380);
    run_cycle();

    // Watchdog: no ready ever.
    apply_reset();
    drive(0, 1, 0, 0, 0, 32'h0);
    run_cycle();
    for (int c = 1; c <= DIV_MAX; c++) begin
      drive(0, 0, 0, 0, 0, 32'h0);
      if (c == DIV_MAX) begin
        #1 check("wd_busy_40", 32'(div_busy), 32'd1);
        check("wd_to_40", 32'(div_timeout), 32'd0);
      end
      run_cycle();
    end
    drive(0, 0, 0, 0, 0, 32'h0);
    #1 check("wd_to_41", 32'(div_timeout), 32'd1);
    check("wd_busy_41", 32'(div_busy), 32'd0);
    check("wd_cnt", stall_cnt, 32'd40);
    for (int c = 0; c < 5; c++) idle_cycle();
    check("wd_sticky", 32'(div_timeout), 32'd1);

    // Async reset mid-cycle while dividing under a MEM wait.
    apply_reset();
    drive(0, 1, 0, 0, 0, 32'h0);
    run_cycle();
    for (int c = 0; c < 3; c++) idle_cycle();
    drive(0, 0, 0, 1, 0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("arst_stall",    32'(stall),     32'd0);
    check("arst_flush",    32'(flush),     32'd0);
    check("arst_div_busy", 32'(div_busy),  32'd0);
    check("arst_cnt",      stall_cnt,      32'd0);
    @(negedge clk);
    apply_reset();

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 4) == 0),
            (!m_busy && $urandom_range(0, 7) == 0),
            (m_busy && $urandom_range(0, 24) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 39) == 0),
            $urandom);
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
